toggle_cover_tracker: RTL and testbench

TOGGLE_COVER_TRACKER -- requirements
Module: toggle_cover_tracker

---
 rtl/toggle_cover_tracker.sv | 116 +++++++++++
 tb/tb_toggle_cover_tracker.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_cover_tracker.sv
// Sticky toggle-coverage tracker: records first hits per point and streams
// their global cover indices out through a valid/ready reporter.
module toggle_cover_tracker #(
    parameter int WIDTH       = 7,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 8940,
    parameter int INDEX_W     = 32,
    localparam int CNT_W      = $clog2(WIDTH + 1),
    localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   valid,
    input  logic               clear,
    input  logic               report_ready,
    output logic               report_valid,
    output logic [INDEX_W-1:0] report_index,
    output logic [WIDTH-1:0]   hit_map,
    output logic [CNT_W-1:0]   hit_count,
    output logic               all_hit
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hit_map_q, hit_map_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [INDEX_W-1:0] report_index_q, report_index_d;

    logic [WIDTH-1:0]   base_map;
    logic [WIDTH-1:0]   sel_src;
    logic [WIDTH-1:0]   first_hit;
    logic [WIDTH-1:0]   grant;
    logic [IDX_W-1:0]   sel_idx;
    logic               take;

    // Clear wipes history first, so same-cycle hits count as first hits.
    always_comb begin
        base_map  = clear ? '0 : hit_map_q;
        sel_src   = clear ? '0 : pending_q;
        first_hit = valid & ~base_map;
        hit_map_d = base_map | valid;
        grant     = sel_src & (~sel_src + WIDTH'(1));
    end

    always_comb begin
        sel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (sel_src[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hit_count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit_count_d = hit_count_d + CNT_W'(hit_map_d[i]);
        end
    end

    always_comb begin
        state_d        = state_q;
        report_index_d = report_index_q;
        take           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|sel_src) begin
                    take    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (report_ready) begin
                    if (|sel_src) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            report_index_d = INDEX_W'(COVER_INDEX) + INDEX_W'(sel_idx);
        end
        pending_d = (sel_src & ~(take ? grant : '0)) | first_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            hit_map_q      <= '0;
            pending_q      <= '0;
            hit_count_q    <= '0;
            report_index_q <= '0;
        end else begin
            state_q        <= state_d;
            hit_map_q      <= hit_map_d;
            pending_q      <= pending_d;
            hit_count_q    <= hit_count_d;
            report_index_q <= report_index_d;
        end
    end

    assign report_valid = (state_q == PRESENT);
    assign report_index = report_index_q;
    assign hit_map      = hit_map_q;
    assign hit_count    = hit_count_q;
    assign all_hit      = (hit_count_q == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_tracker.sv
// Bench for toggle_cover_tracker: scenario tasks plus a report scoreboard.
module tb_toggle_cover_tracker;

    localparam int WIDTH = 7;
    localparam int CIDX  = 100;
    localparam int IW    = 32;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] valid;
    logic             clear;
    logic             report_ready;
    logic             report_valid;
    logic [IW-1:0]    report_index;
    logic [WIDTH-1:0] hit_map;
    logic [CW-1:0]    hit_count;
    logic             all_hit;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    toggle_cover_tracker #(
        .WIDTH(WIDTH), .COVER_INDEX(CIDX), .COVER_TOTAL(8940), .INDEX_W(IW)
    ) dut (
        .clock(clock), .reset(reset), .valid(valid), .clear(clear),
        .report_ready(report_ready), .report_valid(report_valid),
        .report_index(report_index), .hit_map(hit_map),
        .hit_count(hit_count), .all_hit(all_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Every accepted report must match the oldest expected index.
    always @(negedge clock) begin
        if (!reset && report_valid && report_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got index %0d, expected none", report_index);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (report_index !== IW'(e)) begin
                    fails++;
                    $display("FAIL sb_index: got %0d, expected %0d", report_index, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = '0; clear = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = '1; clear = 1'b1; report_ready = 1'b1;
        tick(); tick();
        tests++;
        if (report_valid !== 1'b0 || report_index !== '0) begin
            fails++;
            $display("FAIL reset_report: valid=%b idx=%0d, expected 0/0", report_valid, report_index);
        end
        tests++;
        if (hit_map !== '0 || hit_count !== '0 || all_hit !== 1'b0) begin
            fails++;
            $display("FAIL reset_map: map=%h cnt=%0d all=%b, expected 0/0/0", hit_map, hit_count, all_hit);
        end
        reset = 1'b0; valid = '0; clear = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        report_ready = 1'b1;
        valid = 7'b0000100;
        exp_q.push_back(CIDX + 2);
        tick();
        valid = '0;
        tests++;
        if (hit_map !== 7'h04 || hit_count !== CW'(1) || report_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_c1: map=%h cnt=%0d rv=%b, expected 04/1/0", hit_map, hit_count, report_valid);
        end
        tick();
        tests++;
        if (report_valid !== 1'b1 || report_index !== IW'(CIDX + 2)) begin
            fails++;
            $display("FAIL single_c2: rv=%b idx=%0d, expected 1/102", report_valid, report_index);
        end
        tick();
        tests++;
        if (report_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_c3: rv=%b, expected 0", report_valid);
        end
    endtask

    task automatic test_multi();
        report_ready = 1'b0;
        valid = 7'b1010001;
        exp_q.push_back(CIDX + 0);
        exp_q.push_back(CIDX + 4);
        exp_q.push_back(CIDX + 6);
        tick();
        valid = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (report_valid !== 1'b1 || report_index !== IW'(CIDX)) begin
                fails++;
                $display("FAIL multi_hold%0d: rv=%b idx=%0d, expected 1/100", i, report_valid, report_index);
            end
        end
        report_ready = 1'b1;
        tick();
        tests++;
        if (report_valid !== 1'b1 || report_index !== IW'(CIDX + 4)) begin
            fails++;
            $display("FAIL multi_b2b1: rv=%b idx=%0d, expected 1/104", report_valid, report_index);
        end
        tick();
        tests++;
        if (report_valid !== 1'b1 || report_index !== IW'(CIDX + 6)) begin
            fails++;
            $display("FAIL multi_b2b2: rv=%b idx=%0d, expected 1/106", report_valid, report_index);
        end
        tick();
        tests++;
        if (report_valid !== 1'b0 || hit_map !== 7'h55 || hit_count !== CW'(4)) begin
            fails++;
            $display("FAIL multi_end: rv=%b map=%h cnt=%0d, expected 0/55/4", report_valid, hit_map, hit_count);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        report_ready = 1'b1;
        valid = 7'b0001000;
        exp_q.push_back(CIDX + 3);
        tick();
        valid = '0;
        for (int i = 0; i < 9; i++) tick();
        valid = 7'b0001000;
        tick();
        valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (report_valid !== 1'b0 || hit_count !== CW'(1)) begin
                fails++;
                $display("FAIL repeat_%0d: rv=%b cnt=%0d, expected 0/1", i, report_valid, hit_count);
            end
        end
    endtask

    task automatic test_all_hit_clear();
        int order[6] = '{0, 1, 2, 4, 5, 6};
        report_ready = 1'b1;
        foreach (order[k]) begin
            tests++;
            if (all_hit !== 1'b0) begin
                fails++;
                $display("FAIL allhit_early%0d: all=%b, expected 0", k, all_hit);
            end
            valid = WIDTH'(1) << order[k];
            exp_q.push_back(CIDX + order[k]);
            tick();
        end
        valid = '0;
        tests++;
        if (all_hit !== 1'b1 || hit_count !== CW'(7) || hit_map !== 7'h7f) begin
            fails++;
            $display("FAIL allhit_set: all=%b cnt=%0d map=%h, expected 1/7/7f", all_hit, hit_count, hit_map);
        end
        for (int i = 0; i < 8; i++) tick();
        clear = 1'b1;
        valid = 7'b0000001;
        exp_q.push_back(CIDX);
        tick();
        clear = 1'b0;
        valid = '0;
        tests++;
        if (hit_map !== 7'h01 || hit_count !== CW'(1) || all_hit !== 1'b0) begin
            fails++;
            $display("FAIL clear_hit: map=%h cnt=%0d all=%b, expected 01/1/0", hit_map, hit_count, all_hit);
        end
        tick();
        tests++;
        if (report_valid !== 1'b1 || report_index !== IW'(CIDX)) begin
            fails++;
            $display("FAIL clear_report: rv=%b idx=%0d, expected 1/100", report_valid, report_index);
        end
        tick();
    endtask

    task automatic test_clear_in_present();
        do_reset();
        report_ready = 1'b0;
        valid = 7'b0001000;
        exp_q.push_back(CIDX + 3);
        tick();
        valid = '0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++;
        if (report_valid !== 1'b1 || report_index !== IW'(CIDX + 3) || hit_map !== '0) begin
            fails++;
            $display("FAIL clear_present: rv=%b idx=%0d map=%h, expected 1/103/00", report_valid, report_index, hit_map);
        end
        report_ready = 1'b1;
        tick();
        tests++;
        if (report_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_present_done: rv=%b, expected 0", report_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        report_ready = 1'b0;
        valid = 7'b1100000;
        tick();
        valid = '0;
        tick();
        tests++;
        if (report_valid !== 1'b1 || report_index !== IW'(CIDX + 5)) begin
            fails++;
            $display("FAIL rmid_pre: rv=%b idx=%0d, expected 1/105", report_valid, report_index);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (report_valid !== 1'b0 || hit_map !== '0) begin
            fails++;
            $display("FAIL rmid_reset: rv=%b map=%h, expected 0/00", report_valid, hit_map);
        end
        reset = 1'b0;
        report_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (report_valid !== 1'b0) begin
                fails++;
                $display("FAIL rmid_after%0d: rv=%b idx=%0d, expected 0", i, report_valid, report_index);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        do_reset();
        report_ready = 1'b0;
        valid = 7'b0000010;
        exp_q.push_back(CIDX + 1);
        exp_q.push_back(CIDX + 2);
        tick();
        valid = '0;
        tick();
        tests++;
        if (report_valid !== 1'b1 || report_index !== IW'(CIDX + 1)) begin
            fails++;
            $display("FAIL b2b_pre: rv=%b idx=%0d, expected 1/101", report_valid, report_index);
        end
        report_ready = 1'b1;
        valid = 7'b0000100;
        tick();
        valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (report_valid === 1'b1) begin
                seen = 1'b1;
                tests++;
                if (report_index !== IW'(CIDX + 2)) begin
                    fails++;
                    $display("FAIL b2b_next: idx=%0d, expected 102", report_index);
                end
            end else begin
                tick();
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL b2b_timeout: report_valid=0, expected 102 within 6 cycles");
        end
        tick(); tick();
    endtask

    initial begin
        reset = 1'b1; valid = '0; clear = 1'b0; report_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_repeat();
        test_all_hit_clear();
        test_clear_in_present();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d reports missing, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
